// File: rtl/npc_pkg.sv
// Shared NPC core definitions: decoder instruction classes, sequencer state
// encoding and the default memory wait limit.
package npc_pkg;

    localparam logic [2:0] TYPE_I   = 3'd0;
    localparam logic [2:0] TYPE_U   = 3'd1;
    localparam logic [2:0] TYPE_S   = 3'd2;
    localparam logic [2:0] TYPE_J   = 3'd3;
    localparam logic [2:0] TYPE_R   = 3'd4;
    localparam logic [2:0] TYPE_B   = 3'd5;
    localparam logic [2:0] TYPE_N   = 3'd6;
    localparam logic [2:0] TYPE_ILL = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_BAD    = 3'd7
    } state_e;

    localparam int MEM_TIMEOUT_DEF = 255;

endpackage

// File: rtl/npc_wait_timer.sv
// Handshake wait timer: counts waiting cycles and flags the cycle in which
// the count reaches LIMIT.
module npc_wait_timer #(
    parameter int TMO_W = 8,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      r_cnt <= '0;
        else if (clr) r_cnt <= '0;
        else if (en)  r_cnt <= r_cnt + TMO_W'(1);
    end

    // This waiting cycle is the LIMIT-th one; the owner leaves the wait on it.
    assign expired = en && (r_cnt == TMO_W'(LIMIT - 1));

endmodule

// File: rtl/npc_stage_sequencer.sv
// Multi-cycle NPC control FSM: fetch/decode/exec/mem/wb sequencing, memory
// handshakes, RF/PC write gating, halt on ebreak or fault, perf counters.
module npc_stage_sequencer #(
    parameter int CNT_W       = 64,
    parameter int MEM_TIMEOUT = npc_pkg::MEM_TIMEOUT_DEF,
    parameter int TMO_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             if_req,
    input  logic             if_rvalid,
    output logic             inst_en,
    input  logic [2:0]       inst_type,
    input  logic             memread,
    input  logic             reg_wen,
    input  logic             is_ebreak,
    output logic             mem_req,
    output logic             mem_wr,
    input  logic             mem_ack,
    output logic             rf_wen,
    output logic             pc_wen,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
);
    import npc_pkg::*;

    state_e             r_state;
    logic               r_reg_wen;
    logic               r_memread;
    logic               r_store;
    logic               r_fault;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [CNT_W-1:0]   r_instret;

    state_e             w_next;
    logic               w_waiting;
    logic               w_expired;
    logic               w_fault_set;
    logic               w_retire;
    logic               w_inst_en;

    // FETCH and MEM are never adjacent, so holding clr outside them clears on entry.
    assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEM);

    npc_wait_timer #(
        .TMO_W (TMO_W),
        .LIMIT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (~w_waiting),
        .en      (w_waiting),
        .expired (w_expired)
    );

    always_comb begin
        w_next      = r_state;
        w_fault_set = 1'b0;
        w_retire    = 1'b0;
        w_inst_en   = 1'b0;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_FETCH;
            ST_FETCH: begin
                if (if_rvalid) begin
                    w_inst_en = 1'b1;
                    w_next    = ST_DECODE;
                end else if (w_expired) begin
                    w_next      = ST_HALT;
                    w_fault_set = 1'b1;
                end
            end
            ST_DECODE: begin
                if (inst_type == TYPE_ILL) begin
                    w_next      = ST_HALT;
                    w_fault_set = 1'b1;
                end else if (inst_type == TYPE_N && is_ebreak) begin
                    w_next   = ST_HALT;
                    w_retire = 1'b1;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC:   w_next = (r_memread || r_store) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (mem_ack) begin
                    w_next = ST_WB;
                end else if (w_expired) begin
                    w_next      = ST_HALT;
                    w_fault_set = 1'b1;
                end
            end
            ST_WB: begin
                w_next   = ST_FETCH;
                w_retire = 1'b1;
            end
            ST_HALT:   w_next = ST_HALT;
            default: begin
                w_next      = ST_HALT;
                w_fault_set = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_reg_wen   <= 1'b0;
            r_memread   <= 1'b0;
            r_store     <= 1'b0;
            r_fault     <= 1'b0;
            r_cycle_cnt <= '0;
            r_instret   <= '0;
        end else begin
            r_state <= w_next;
            r_fault <= r_fault | w_fault_set;
            if (r_state == ST_DECODE) begin
                r_reg_wen <= reg_wen;
                r_memread <= memread;
                r_store   <= (inst_type == TYPE_S);
            end
            if (r_state != ST_IDLE && r_state != ST_HALT)
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (w_retire)
                r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign if_req    = (r_state == ST_FETCH);
    assign inst_en   = w_inst_en;
    assign mem_req   = (r_state == ST_MEM);
    assign mem_wr    = (r_state == ST_MEM) && r_store;
    assign pc_wen    = (r_state == ST_WB);
    assign rf_wen    = (r_state == ST_WB) && r_reg_wen && !r_store;
    assign halted    = (r_state == ST_HALT);
    assign fault     = r_fault;
    assign state     = r_state;
    assign cycle_cnt = r_cycle_cnt;
    assign instret   = r_instret;

endmodule

// File: tb/tb_npc_stage_sequencer.sv
// Scoreboard bench for npc_stage_sequencer: randomized instruction streams
// against a per-instruction cycle-cost model, plus directed corner cases.
module tb_npc_stage_sequencer;
    import npc_pkg::*;

    localparam int CNT_W = 64;
    localparam int TMO   = 4;
    localparam int TMO_W = 8;
    localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_EBRK = 3, K_ILL = 4;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, if_rvalid = 1'b0, mem_ack = 1'b0;
    logic memread = 1'b0, reg_wen = 1'b0, is_ebreak = 1'b0;
    logic [2:0] inst_type = 3'd0;
    logic if_req, inst_en, mem_req, mem_wr, rf_wen, pc_wen, halted, fault;
    logic [2:0] state;
    logic [CNT_W-1:0] cycle_cnt, instret;

    typedef struct { int kind; logic [2:0] ty; int fw; int mw; logic rw; logic stray; } instr_t;
    typedef struct { logic rf; longint ret; longint cyc; } wb_t;
    typedef struct { int len; logic wr; } mem_t;

    wb_t  q_wb[$];
    mem_t q_mem[$];
    int   n_chk = 0, n_fail = 0;
    int   n_inst_en = 0;
    longint m_cyc, m_ret;
    int   m_fetch;
    logic m_fault;

    always #5 clk = ~clk;

    npc_stage_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO), .TMO_W(TMO_W)) dut (
        .clk(clk), .rst(rst), .start(start), .if_req(if_req), .if_rvalid(if_rvalid),
        .inst_en(inst_en), .inst_type(inst_type), .memread(memread), .reg_wen(reg_wen),
        .is_ebreak(is_ebreak), .mem_req(mem_req), .mem_wr(mem_wr), .mem_ack(mem_ack),
        .rf_wen(rf_wen), .pc_wen(pc_wen), .halted(halted), .fault(fault), .state(state),
        .cycle_cnt(cycle_cnt), .instret(instret)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sig(input int which, input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if ((which == 0 && if_req === 1'b1) || (which == 1 && mem_req === 1'b1) ||
                (which == 2 && halted === 1'b1)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_%s: never asserted within 64 cycles, required 1", nm);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a WB or finishes a MEM burst.
    initial begin
        int   mlen;
        logic mwr;
        wb_t  ew;
        mem_t em;
        mlen = 0;
        mwr  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mlen = 0;
            end else begin
                if (inst_en === 1'b1) n_inst_en++;
                if (mem_req === 1'b1) begin
                    if (mlen == 0) mwr = mem_wr;
                    else if (mem_wr !== mwr) check("mem_wr_stable", mem_wr, mwr);
                    mlen++;
                end else if (mlen != 0) begin
                    if (q_mem.size() == 0) check("mem_unexpected", 1, 0);
                    else begin
                        em = q_mem.pop_front();
                        check("mem_req_cycles", mlen, em.len);
                        check("mem_wr", mwr, em.wr);
                    end
                    mlen = 0;
                end
                if (pc_wen === 1'b1) begin
                    if (q_wb.size() == 0) check("wb_unexpected", 1, 0);
                    else begin
                        ew = q_wb.pop_front();
                        check("wb_rf_wen", rf_wen, ew.rf);
                        check("wb_instret", instret, ew.ret);
                        check("wb_cycle_cnt", cycle_cnt, ew.cyc);
                    end
                end else if (rf_wen !== 1'b0) begin
                    check("rf_wen_outside_wb", rf_wen, 0);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1; start = 1'b0; if_rvalid = 1'b0; mem_ack = 1'b0;
        #1;
        check("rst_state", state, 0);
        check("rst_outputs", {if_req, mem_req, mem_wr, rf_wen, pc_wen, halted, fault}, 0);
        check("rst_cycle_cnt", cycle_cnt, 0);
        check("rst_instret", instret, 0);
        tick();
        rst = 1'b0;
        q_wb.delete(); q_mem.delete();
        m_cyc = 0; m_ret = 0; m_fetch = 0; m_fault = 1'b0; n_inst_en = 0;
        tick();
        check("idle_hold_state", state, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic instr_t mk(int kind, int fw, int mw, logic rw, logic stray, logic [2:0] ty);
        instr_t r;
        r.kind = kind; r.fw = fw; r.mw = mw; r.rw = rw; r.stray = stray; r.ty = ty;
        return r;
    endfunction

    // Issues one instruction; returns done=1 once the core is expected to halt.
    task automatic run_instr(input instr_t in, output bit done);
        bit     ok;
        longint cost;
        wb_t    ew;
        done = 1'b0;
        wait_sig(0, "if_req", ok);
        if (!ok) begin done = 1'b1; return; end
        check("fetch_cycle_cnt", cycle_cnt, m_cyc);
        check("fetch_instret", instret, m_ret);
        repeat (in.fw) tick();
        reg_wen   = in.rw;
        memread   = (in.kind == K_LD);
        is_ebreak = (in.kind == K_EBRK);
        case (in.kind)
            K_LD:    inst_type = TYPE_I;
            K_ST:    inst_type = TYPE_S;
            K_EBRK:  inst_type = TYPE_N;
            K_ILL:   inst_type = TYPE_ILL;
            default: inst_type = in.ty;
        endcase
        if_rvalid = 1'b1;
        tick();
        if_rvalid = 1'b0;
        m_fetch++;
        cost = in.fw + 2;
        if (in.kind == K_EBRK || in.kind == K_ILL) begin
            m_cyc += cost;
            if (in.kind == K_EBRK) m_ret++;
            m_fault = (in.kind == K_ILL);
            done = 1'b1;
            return;
        end
        if (in.kind == K_ALU) begin
            cost += 2;
            ew.rf = in.rw; ew.ret = m_ret; ew.cyc = m_cyc + cost - 1;
            q_wb.push_back(ew);
            m_cyc += cost; m_ret++;
            if (in.stray) begin
                tick();
                mem_ack = 1'b1;
                tick();
                mem_ack = 1'b0;
            end
            return;
        end
        cost += 1;
        if (in.mw + 1 <= TMO) begin
            q_mem.push_back('{len: in.mw + 1, wr: (in.kind == K_ST)});
            cost += in.mw + 2;
            ew.rf = in.rw && (in.kind != K_ST); ew.ret = m_ret; ew.cyc = m_cyc + cost - 1;
            q_wb.push_back(ew);
            m_cyc += cost; m_ret++;
            wait_sig(1, "mem_req", ok);
            if (!ok) begin done = 1'b1; return; end
            repeat (in.mw) tick();
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end else begin
            q_mem.push_back('{len: TMO, wr: (in.kind == K_ST)});
            m_cyc += cost + TMO;
            m_fault = 1'b1;
            done = 1'b1;
        end
    endtask

    task automatic end_episode(input string tag);
        bit ok;
        wait_sig(2, {tag, "_halted"}, ok);
        tick();
        check({tag, "_state"}, state, 6);
        check({tag, "_fault"}, fault, m_fault);
        check({tag, "_instret"}, instret, m_ret);
        check({tag, "_cycle_cnt"}, cycle_cnt, m_cyc);
        check({tag, "_inst_en_count"}, n_inst_en, m_fetch);
        check({tag, "_queues_drained"}, q_wb.size() + q_mem.size(), 0);
        start = 1'b1; if_rvalid = 1'b1; mem_ack = 1'b1;
        repeat (3) tick();
        check({tag, "_sticky_strobes"}, {inst_en, if_req, mem_req, pc_wen, rf_wen}, 0);
        start = 1'b0; if_rvalid = 1'b0; mem_ack = 1'b0;
        check({tag, "_sticky_state"}, {halted, state}, {1'b1, 3'd6});
        check({tag, "_sticky_counters"}, cycle_cnt + instret, m_cyc + m_ret);
    endtask

    task automatic run_list(input instr_t lst[$], input string tag);
        bit done;
        do_reset();
        foreach (lst[i]) begin
            run_instr(lst[i], done);
            if (done) break;
        end
        end_episode(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t lst[$];
        bit     ok;
        logic [2:0] alu_ty[6];
        alu_ty = '{TYPE_I, TYPE_U, TYPE_J, TYPE_R, TYPE_B, TYPE_N};

        // ALU op, then ebreak
        lst = '{mk(K_ALU, 2, 0, 1'b1, 1'b0, TYPE_R), mk(K_EBRK, 0, 0, 1'b0, 1'b0, TYPE_N)};
        run_list(lst, "alu");
        // load (3 MEM cycles), store, ebreak
        lst = '{mk(K_LD, 0, 2, 1'b1, 1'b0, TYPE_I), mk(K_ST, 1, 0, 1'b0, 1'b0, TYPE_S),
                mk(K_EBRK, 1, 0, 1'b0, 1'b0, TYPE_N)};
        run_list(lst, "ldst");
        // memory timeout
        lst = '{mk(K_ALU, 0, 0, 1'b1, 1'b1, TYPE_U), mk(K_LD, 0, TMO, 1'b1, 1'b0, TYPE_I)};
        run_list(lst, "timeout");
        // ack coincides with expiry, then illegal type
        lst = '{mk(K_ST, 0, TMO - 1, 1'b1, 1'b0, TYPE_S), mk(K_ILL, 0, 0, 1'b1, 1'b0, TYPE_ILL)};
        run_list(lst, "ack_at_expiry");

        // asynchronous reset while a load waits in MEM
        do_reset();
        wait_sig(0, "mr_if_req", ok);
        memread = 1'b1; inst_type = TYPE_I; is_ebreak = 1'b0; reg_wen = 1'b1;
        if_rvalid = 1'b1;
        tick();
        if_rvalid = 1'b0;
        wait_sig(1, "mr_mem_req", ok);
        tick();
        check("mr_mem_req_before", mem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mr_mem_req", mem_req, 0);
        check("mr_state", state, 0);
        check("mr_counters", cycle_cnt | instret, 0);
        tick();
        rst = 1'b0;

        // randomized instruction streams
        for (int ep = 0; ep < 20; ep++) begin
            int n;
            lst.delete();
            n = $urandom_range(8, 2);
            for (int k = 0; k < n; k++) begin
                int  kind;
                kind = $urandom_range(2, 0);
                lst.push_back(mk(kind, $urandom_range(3, 0), $urandom_range(TMO, 0),
                                 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                                 alu_ty[$urandom_range(5, 0)]));
            end
            if ($urandom_range(1, 0) == 1) lst.push_back(mk(K_EBRK, $urandom_range(2, 0), 0, 1'b0, 1'b0, TYPE_N));
            else                           lst.push_back(mk(K_ILL, $urandom_range(2, 0), 0, 1'b1, 1'b0, TYPE_ILL));
            run_list(lst, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
